lcd_cmd_ctrl: RTL and testbench

LCD_CMD_CTRL -- requirements
Module: lcd_cmd_ctrl

---
 rtl/lcd_cmd_ctrl.sv | 266 ++++++++++++++++++++++++++
 tb/tb_lcd_cmd_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/lcd_cmd_ctrl.sv
// lcd_cmd_ctrl: UART command decoder that maintains the background/foreground
// colours, a highlight rectangle and a drawing mode, and produces the RGB565
// colour for the pixel currently addressed by the st7735 driver.
// Each packet is acknowledged with ACK_BYTE or rejected with NAK_BYTE.
module lcd_cmd_ctrl #(
    parameter int         TIMEOUT_CYCLES = 1200000,
    parameter logic [7:0] ACK_BYTE       = 8'h06,
    parameter logic [7:0] NAK_BYTE       = 8'h15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic        tx_busy,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    input  logic [7:0]  x,
    input  logic [6:0]  y,
    output logic [15:0] color,
    output logic        busy,
    output logic        err
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PAYLOAD = 2'd1,
        S_RESP    = 2'd2
    } state_t;

    // Index of the final payload byte for each opcode.
    function automatic logic [1:0] last_idx(input logic [2:0] op);
        case (op)
            3'd1, 3'd2: last_idx = 2'd1;
            3'd3:       last_idx = 2'd3;
            default:    last_idx = 2'd0;
        endcase
    endfunction

    state_t          r_state;
    state_t          w_state_nxt;
    logic [2:0]      r_op;
    logic [1:0]      r_idx;
    logic            r_commit;   // last payload byte captured, apply next cycle
    logic [CW-1:0]   r_cnt;
    logic [3:0][7:0] r_sh;
    logic [15:0]     r_bg, r_fg;
    logic [7:0]      r_x0, r_x1;
    logic [6:0]      r_y0, r_y1;
    logic [1:0]      r_mode;
    logic            r_ack;
    logic            r_tx_start;
    logic [7:0]      r_tx_data;
    logic            r_busy;
    logic            r_err;
    logic [15:0]     r_color;

    logic            w_op_ok;
    logic            w_cmd_ok;
    logic            w_timeout;
    logic            w_decide, w_decide_ack, w_apply, w_emit, w_drop;
    logic            w_in_rect;
    logic [15:0]     w_color;

    assign w_op_ok   = (rx_data >= 8'd1) && (rx_data <= 8'd4);
    assign w_cmd_ok  = (r_op != 3'd4) || (r_sh[0] <= 8'd2);
    // A byte arriving in the same cycle as the timeout wins.
    assign w_timeout = (r_state == S_PAYLOAD) && !r_commit && !rx_valid &&
                       (r_cnt == CW'(TIMEOUT_CYCLES));

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (rx_valid) begin
                    w_state_nxt = w_op_ok ? S_PAYLOAD : S_RESP;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_PAYLOAD: begin
                if (r_commit || w_timeout) begin
                    w_state_nxt = S_RESP;
                end else begin
                    w_state_nxt = S_PAYLOAD;
                end
            end
            S_RESP: begin
                if (!tx_busy) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_RESP;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Per-state control strobes: response decision, commit, emission, drops.
    always_comb begin
        w_decide     = 1'b0;
        w_decide_ack = 1'b0;
        w_apply      = 1'b0;
        w_emit       = 1'b0;
        w_drop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (rx_valid && !w_op_ok) begin
                    w_decide = 1'b1;
                end else begin
                    w_decide = 1'b0;
                end
            end
            S_PAYLOAD: begin
                if (r_commit) begin
                    w_decide     = 1'b1;
                    w_decide_ack = w_cmd_ok;
                    w_apply      = w_cmd_ok;
                    w_drop       = rx_valid;
                end else if (w_timeout) begin
                    w_decide = 1'b1;
                end else begin
                    w_decide = 1'b0;
                end
            end
            S_RESP: begin
                w_emit = !tx_busy;
                w_drop = rx_valid;
            end
            default: begin
                w_decide = 1'b0;
            end
        endcase
    end

    // Packet collection: opcode, byte index, inter-byte counter and shadows.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_op     <= 3'd0;
            r_idx    <= 2'd0;
            r_commit <= 1'b0;
            r_cnt    <= '0;
            r_sh     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_commit <= 1'b0;
                    r_cnt    <= '0;
                    r_idx    <= 2'd0;
                    if (rx_valid && w_op_ok) begin
                        r_op <= rx_data[2:0];
                    end
                end
                S_PAYLOAD: begin
                    if (r_commit) begin
                        r_commit <= 1'b0;
                    end else if (rx_valid) begin
                        r_sh[r_idx] <= rx_data;
                        r_idx       <= r_idx + 2'd1;
                        r_cnt       <= '0;
                        if (r_idx == last_idx(r_op)) begin
                            r_commit <= 1'b1;
                        end
                    end else if (w_timeout) begin
                        r_sh  <= '0;
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_commit <= 1'b0;
                end
            endcase
        end
    end

    // Live configuration, updated atomically from the shadows on commit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bg   <= 16'h0000;
            r_fg   <= 16'hFFFF;
            r_x0   <= 8'd0;
            r_y0   <= 7'd0;
            r_x1   <= 8'd159;
            r_y1   <= 7'd127;
            r_mode <= 2'd0;
        end else if (w_apply) begin
            case (r_op)
                3'd1: r_bg <= {r_sh[0], r_sh[1]};
                3'd2: r_fg <= {r_sh[0], r_sh[1]};
                3'd3: begin
                    r_x0 <= r_sh[0];
                    r_y0 <= r_sh[1][6:0];
                    r_x1 <= r_sh[2];
                    r_y1 <= r_sh[3][6:0];
                end
                3'd4: r_mode <= r_sh[0][1:0];
                default: r_mode <= r_mode;
            endcase
        end
    end

    // Response byte, transmit strobe, busy and sticky error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ack      <= 1'b0;
            r_tx_start <= 1'b0;
            r_tx_data  <= 8'h00;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_tx_start <= w_emit;
            r_busy     <= (w_state_nxt != S_IDLE);
            if (w_emit) begin
                r_tx_data <= r_ack ? ACK_BYTE : NAK_BYTE;
            end
            if (w_decide) begin
                r_ack <= w_decide_ack;
            end
            if (w_decide && w_decide_ack) begin
                r_err <= 1'b0;
            end else if ((w_decide && !w_decide_ack) || w_drop) begin
                r_err <= 1'b1;
            end
        end
    end

    // Pixel colour selection from the live configuration.
    always_comb begin
        w_in_rect = (x >= r_x0) && (x <= r_x1) && (y >= r_y0) && (y <= r_y1);
        case (r_mode)
            2'd0:    w_color = r_bg;
            2'd1:    w_color = w_in_rect ? r_fg : r_bg;
            2'd2:    w_color = (x[3] ^ y[3]) ? r_fg : r_bg;
            default: w_color = r_bg;
        endcase
    end

    // Registered pixel colour, one cycle behind x/y.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_color <= 16'h0000;
        end else begin
            r_color <= w_color;
        end
    end

    assign tx_start = r_tx_start;
    assign tx_data  = r_tx_data;
    assign busy     = r_busy;
    assign err      = r_err;
    assign color    = r_color;

endmodule

// File: tb/tb_lcd_cmd_ctrl.sv
// Directed testbench for lcd_cmd_ctrl.
module tb_lcd_cmd_ctrl;

    localparam int TMO = 40;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        tx_busy = 1'b0;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic [7:0]  x = 8'd0;
    logic [6:0]  y = 7'd0;
    logic [15:0] color;
    logic        busy;
    logic        err;

    int errors = 0;
    int checks = 0;
    int n_tx = 0;
    logic [7:0] last_tx = 8'h00;

    lcd_cmd_ctrl #(.TIMEOUT_CYCLES(TMO), .ACK_BYTE(8'h06), .NAK_BYTE(8'h15)) dut (
        .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data),
        .x(x), .y(y), .color(color), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // Record every transmit pulse away from the active edge.
    always @(negedge clk) begin
        if (tx_start === 1'b1) begin
            n_tx    <= n_tx + 1;
            last_tx <= tx_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic expect_resp(input string tag, input logic [7:0] exp, input int budget);
        int start;
        start = n_tx;
        for (int i = 0; i < budget && n_tx == start; i++) @(posedge clk);
        @(negedge clk);
        check({tag, "_count"}, n_tx - start, 1);
        check({tag, "_byte"}, {24'd0, last_tx}, {24'd0, exp});
    endtask

    task automatic check_pix(input string tag, input logic [7:0] px, input logic [6:0] py,
                             input logic [15:0] exp);
        x = px;
        y = py;
        @(negedge clk);
        check(tag, {16'd0, color}, {16'd0, exp});
    endtask

    initial begin
        int start;
        // Reset state
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_tx_start", {31'd0, tx_start}, 0);
        check("rst_tx_data", {24'd0, tx_data}, 0);
        check("rst_color", {16'd0, color}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_err", {31'd0, err}, 0);

        // SET_FG then mode 0: colour stays background
        send_byte(8'h02); send_byte(8'hF8); send_byte(8'h00);
        check("busy_payload", {31'd0, busy}, 1);
        expect_resp("fg_ack", 8'h06, 10);
        check("fg_err", {31'd0, err}, 0);
        check_pix("m0_pix", 8'd10, 7'd5, 16'h0000);
        send_byte(8'h04); send_byte(8'h00);
        expect_resp("m0_ack", 8'h06, 10);
        check_pix("m0_pix2", 8'd10, 7'd5, 16'h0000);

        // Rectangle mode
        send_byte(8'h03); send_byte(8'h0A); send_byte(8'h05); send_byte(8'h14); send_byte(8'h0A);
        expect_resp("rect_ack", 8'h06, 10);
        send_byte(8'h02); send_byte(8'hF8); send_byte(8'h00);
        expect_resp("fg2_ack", 8'h06, 10);
        send_byte(8'h04); send_byte(8'h01);
        expect_resp("m1_ack", 8'h06, 10);
        check_pix("rect_in_lo", 8'd10, 7'd5, 16'hF800);
        check_pix("rect_in_hi", 8'd20, 7'd10, 16'hF800);
        check_pix("rect_out_x", 8'd21, 7'd10, 16'h0000);
        check_pix("rect_out_lo", 8'd9, 7'd5, 16'h0000);

        // Checker mode
        send_byte(8'h04); send_byte(8'h02);
        expect_resp("m2_ack", 8'h06, 10);
        check_pix("chk_fg", 8'd8, 7'd0, 16'hF800);
        check_pix("chk_bg", 8'd8, 7'd8, 16'h0000);

        // Empty rectangle (x0 > x1)
        send_byte(8'h04); send_byte(8'h01);
        expect_resp("m1b_ack", 8'h06, 10);
        send_byte(8'h03); send_byte(8'h14); send_byte(8'h05); send_byte(8'h0A); send_byte(8'h0A);
        expect_resp("empty_ack", 8'h06, 10);
        check_pix("empty_a", 8'd15, 7'd5, 16'h0000);
        check_pix("empty_b", 8'd20, 7'd5, 16'h0000);

        // y payload bit 7 ignored: rows 5..5 via 0x85
        send_byte(8'h03); send_byte(8'h00); send_byte(8'h85); send_byte(8'h9F); send_byte(8'h85);
        expect_resp("ybit_ack", 8'h06, 10);
        check_pix("ybit_in", 8'd50, 7'd5, 16'hF800);
        check_pix("ybit_out", 8'd50, 7'd6, 16'h0000);

        // Bad opcode
        send_byte(8'h7F);
        expect_resp("badop_nak", 8'h15, 10);
        check("badop_err", {31'd0, err}, 1);
        check_pix("badop_keep", 8'd50, 7'd5, 16'hF800);
        send_byte(8'h04); send_byte(8'h01);
        expect_resp("recover_ack", 8'h06, 10);
        check("recover_err", {31'd0, err}, 0);

        // Bad mode value
        send_byte(8'h04); send_byte(8'h03);
        expect_resp("badmode_nak", 8'h15, 10);
        check("badmode_err", {31'd0, err}, 1);
        check_pix("badmode_in", 8'd50, 7'd5, 16'hF800);
        check_pix("badmode_out", 8'd50, 7'd6, 16'h0000);

        // Timeout discards partial SET_BG
        send_byte(8'h04); send_byte(8'h00);
        expect_resp("m0b_ack", 8'h06, 10);
        send_byte(8'h01); send_byte(8'h12);
        start = n_tx;
        repeat (TMO - 5) @(negedge clk);
        check("tmo_early", n_tx - start, 0);
        expect_resp("tmo_nak", 8'h15, 30);
        check("tmo_busy", {31'd0, busy}, 0);
        check("tmo_err", {31'd0, err}, 1);
        check_pix("tmo_bg", 8'd0, 7'd0, 16'h0000);

        // Byte arriving exactly at the timeout cycle is accepted
        send_byte(8'h01); send_byte(8'h12);
        repeat (TMO - 1) @(negedge clk);
        send_byte(8'h34);
        expect_resp("edge_ack", 8'h06, 10);
        check_pix("edge_bg", 8'd0, 7'd0, 16'h1234);

        // Transmitter busy holds the response; byte during wait is dropped
        tx_busy = 1'b1;
        send_byte(8'h04); send_byte(8'h00);
        start = n_tx;
        repeat (10) @(negedge clk);
        send_byte(8'h55);
        repeat (38) @(negedge clk);
        check("hold_no_tx", n_tx - start, 0);
        check("hold_busy", {31'd0, busy}, 1);
        check("drop_err", {31'd0, err}, 1);
        tx_busy = 1'b0;
        expect_resp("hold_ack", 8'h06, 5);
        repeat (5) @(negedge clk);
        check("hold_once", n_tx - start, 1);
        check("hold_idle", {31'd0, busy}, 0);
        check("hold_err", {31'd0, err}, 1);

        // Reset mid-packet aborts it; rectangle back to full screen
        send_byte(8'h03); send_byte(8'h01); send_byte(8'h02);
        start = n_tx;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("abort_no_tx", n_tx - start, 0);
        check("abort_busy", {31'd0, busy}, 0);
        check("abort_err", {31'd0, err}, 0);
        send_byte(8'h04); send_byte(8'h01);
        expect_resp("post_rst_ack", 8'h06, 10);
        check_pix("full_rect_hi", 8'd159, 7'd127, 16'hFFFF);
        check_pix("full_rect_lo", 8'd0, 7'd0, 16'hFFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
